// File: rtl/mult_share_sched.sv
// Round-robin scheduler that time-shares one external combinational W x W multiplier
// among NREQ valid/ready requesters and returns the product with the owner's index.
module mult_share_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned W       = 4,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned IDW     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*W-1:0]   req_x,
  input  logic [NREQ*W-1:0]   req_y,
  output logic [W-1:0]        mul_x,
  output logic [W-1:0]        mul_y,
  input  logic [2*W-1:0]      mul_o,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*W-1:0]      rsp_o,
  output logic [IDW-1:0]      rsp_id
);

  localparam int unsigned     CW   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [IDW-1:0]  LAST = IDW'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt;
  logic [IDW-1:0] idx;
  logic           found;
  logic           accept;
  logic           capture;
  logic           done;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   x_sel;
  logic [W-1:0]   y_sel;

  // Round-robin search starting at ptr
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(ptr) + k) % NREQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  // Operand mux for the granted requester
  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) begin
        x_sel = req_x[i*W +: W];
        y_sel = req_y[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept    = 1'b0;
    capture   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready = NREQ'(1) << gnt;
          accept    = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands stay put after capture; they only move on a new acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      cnt       <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      rsp_id    <= '0;
      rsp_o     <= '0;
      rsp_valid <= 1'b0;
    end else begin
      if (accept) begin
        mul_x  <= x_sel;
        mul_y  <= y_sel;
        rsp_id <= gnt;
        ptr    <= (gnt == LAST) ? '0 : gnt + IDW'(1);
        cnt    <= CW'(MUL_LAT - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (capture) begin
        rsp_o     <= mul_o;
        rsp_valid <= 1'b1;
      end else if (done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched: one instance with MUL_LAT=1, one with MUL_LAT=3,
// each driving a behavioural multiplier on mul_x/mul_y.
module tb_mult_share_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // MUL_LAT = 1 instance
  logic        rst1 = 1'b1;
  logic [3:0]  v1 = '0, ready1;
  logic [15:0] x1 = '0, y1 = '0;
  logic [3:0]  mx1, my1;
  logic [7:0]  mo1, ro1;
  logic        rv1, rr1 = 1'b0;
  logic [1:0]  rid1;
  assign mo1 = {4'b0, mx1} * {4'b0, my1};

  mult_share_sched #(.NREQ(4), .W(4), .MUL_LAT(1), .IDW(2)) u_dut1 (
    .clk(clk), .rst(rst1), .req_valid(v1), .req_ready(ready1), .req_x(x1), .req_y(y1),
    .mul_x(mx1), .mul_y(my1), .mul_o(mo1), .rsp_valid(rv1), .rsp_ready(rr1),
    .rsp_o(ro1), .rsp_id(rid1)
  );

  // MUL_LAT = 3 instance
  logic        rst3 = 1'b1;
  logic [3:0]  v3 = '0, ready3;
  logic [15:0] x3 = '0, y3 = '0;
  logic [3:0]  mx3, my3;
  logic [7:0]  mo3, ro3;
  logic        rv3, rr3 = 1'b1;
  logic [1:0]  rid3;
  assign mo3 = {4'b0, mx3} * {4'b0, my3};

  mult_share_sched #(.NREQ(4), .W(4), .MUL_LAT(3), .IDW(2)) u_dut3 (
    .clk(clk), .rst(rst3), .req_valid(v3), .req_ready(ready3), .req_x(x3), .req_y(y3),
    .mul_x(mx3), .mul_y(my3), .mul_o(mo3), .rsp_valid(rv3), .rsp_ready(rr3),
    .rsp_o(ro3), .rsp_id(rid3)
  );

  // Transaction log for the MUL_LAT=1 instance
  int         acc_id[$];
  int         acc_cyc[$];
  logic [7:0] rsp_d[$];
  int         rsp_i[$];
  int         n13 = 0;
  always @(posedge clk) begin
    if (!rst1) begin
      for (int i = 0; i < 4; i++)
        if (v1[i] && ready1[i]) begin
          acc_id.push_back(i);
          acc_cyc.push_back(cyc);
        end
      if (rv1 && rr1) begin
        rsp_d.push_back(ro1);
        rsp_i.push_back(int'(rid1));
      end
      if (ready1[1] || ready1[3]) n13 = n13 + 1;
    end
  end

  task automatic reset1();
    @(negedge clk);
    rst1 = 1'b1;
    v1   = '0;
    @(negedge clk);
    @(negedge clk);
    rst1 = 1'b0;
  endtask

  task automatic wait_acc(input int n, input string tag);
    int guard = 0;
    while (acc_id.size() < n && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 32'(acc_id.size() >= n), 32'd1);
  endtask

  task automatic wait_rsp(input int n, input string tag);
    int guard = 0;
    while (rsp_d.size() < n && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 32'(rsp_d.size() >= n), 32'd1);
  endtask

  int b, rb, base13, k, nrv;

  initial begin
    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready1), 32'h0);
    check("rst_rv",    32'(rv1),    32'h0);
    check("rst_ro",    32'(ro1),    32'h0);
    check("rst_rid",   32'(rid1),   32'h0);
    check("rst_mx",    32'(mx1),    32'h0);
    check("rst_my",    32'(my1),    32'h0);
    rst1 = 1'b0;
    rst3 = 1'b0;

    // 1: single request from req1
    @(negedge clk);
    rr1 = 1'b1;
    x1  = 16'h0030;
    y1  = 16'h0050;
    v1  = 4'b0010;
    #1 check("t1_ready", 32'(ready1), 32'h2);
    @(negedge clk);
    v1 = '0;
    check("t1_mx", 32'(mx1), 32'd3);
    check("t1_my", 32'(my1), 32'd5);
    check("t1_rv_wait", 32'(rv1), 32'd0);
    @(negedge clk);
    check("t1_rv", 32'(rv1), 32'd1);
    check("t1_ro", 32'(ro1), 32'h0F);
    check("t1_rid", 32'(rid1), 32'd1);
    @(negedge clk);
    check("t1_rv_low", 32'(rv1), 32'd0);

    // 2: all four valid, x=y=15
    reset1();
    b  = acc_id.size();
    rb = rsp_d.size();
    x1 = 16'hFFFF;
    y1 = 16'hFFFF;
    v1 = 4'b1111;
    wait_acc(b + 5, "t2_acc_timeout");
    v1 = '0;
    wait_rsp(rb + 5, "t2_rsp_timeout");
    for (int i = 0; i < 5; i++) begin
      check("t2_gnt",  32'(acc_id[b+i]), 32'(i % 4));
      check("t2_ro",   32'(rsp_d[rb+i]), 32'hE1);
      check("t2_rid",  32'(rsp_i[rb+i]), 32'(i % 4));
      if (i > 0) check("t2_spacing", 32'(acc_cyc[b+i] - acc_cyc[b+i-1]), 32'd3);
    end

    // 3: req0 and req2 only
    reset1();
    b      = acc_id.size();
    rb     = rsp_d.size();
    base13 = n13;
    x1 = 16'h0502;
    y1 = 16'h0703;
    v1 = 4'b0101;
    wait_acc(b + 8, "t3_acc_timeout");
    v1 = '0;
    wait_rsp(rb + 8, "t3_rsp_timeout");
    for (int i = 0; i < 8; i++) begin
      check("t3_gnt", 32'(acc_id[b+i]), (i % 2 == 0) ? 32'd0 : 32'd2);
      check("t3_ro",  32'(rsp_d[rb+i]), (i % 2 == 0) ? 32'd6 : 32'd35);
    end
    check("t3_no_ready_1_3", 32'(n13 - base13), 32'd0);

    // 4: response backpressure
    reset1();
    rr1 = 1'b0;
    x1  = 16'h0207;
    y1  = 16'h0309;
    v1  = 4'b0001;
    @(negedge clk);
    v1 = 4'b0100;
    k  = 0;
    while (!rv1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("t4_rv", 32'(rv1), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_rv",  32'(rv1),    32'd1);
      check("t4_hold_ro",  32'(ro1),    32'h3F);
      check("t4_hold_rid", 32'(rid1),   32'd0);
      check("t4_ready0",   32'(ready1), 32'h0);
    end
    rr1 = 1'b1;
    @(negedge clk);
    check("t4_rv_done", 32'(rv1), 32'd0);
    check("t4_next_gnt", 32'(ready1), 32'h4);
    @(negedge clk);
    v1 = '0;
    @(negedge clk);
    check("t4_ro2", 32'(ro1), 32'd6);
    check("t4_rid2", 32'(rid1), 32'd2);

    // 5: reset while in WAIT (MUL_LAT=3)
    @(negedge clk);
    x3 = 16'h0900;
    y3 = 16'h0900;
    v3 = 4'b0100;
    #1 check("t5_ready", 32'(ready3), 32'h4);
    @(negedge clk);
    v3   = '0;
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    check("t5_rv", 32'(rv3), 32'd0);
    check("t5_mx", 32'(mx3), 32'd0);
    nrv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rv3) nrv++;
    end
    check("t5_no_rsp", 32'(nrv), 32'd0);
    x3 = 16'h1001;
    y3 = 16'h1001;
    v3 = 4'b1001;
    #1 check("t5_gnt0", 32'(ready3), 32'h1);
    @(negedge clk);
    v3 = '0;
    for (int i = 0; i < 6; i++) @(negedge clk);

    // 6: exhaustive operands on req3, MUL_LAT=3
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        @(negedge clk);
        x3 = {4'(x), 12'h000};
        y3 = {4'(y), 12'h000};
        v3 = 4'b1000;
        k  = 0;
        do begin
          @(negedge clk);
          v3 = '0;
          k++;
        end while (!rv3 && k < 10);
        check("t6_lat", 32'(k), 32'd4);
        check("t6_ro",  32'(ro3), 32'(x * y));
        check("t6_rid", 32'(rid3), 32'd3);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
